// File: rtl/fft_pkg.sv
// Shared types and constants for the radix-2 butterfly unit.
// Q1.15 complex type, widths, rounding constant, saturation helper.
package fft_pkg;

  localparam int DW    = 16;
  localparam int TW_AW = 4;

  localparam logic signed [2*DW:0] RND_Q15 =
    (2*DW+1)'(2**(DW-2));

  localparam logic signed [DW+1:0] SAT_MAX =
    (DW+2)'(2**(DW-1) - 1);
  localparam logic signed [DW+1:0] SAT_MIN = ~SAT_MAX;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  function automatic logic signed [DW-1:0] sat_dw(
    input logic signed [DW+1:0] v
  );
    if (v > SAT_MAX)
      return SAT_MAX[DW-1:0];
    else if (v < SAT_MIN)
      return SAT_MIN[DW-1:0];
    else
      return v[DW-1:0];
  endfunction

endpackage

// File: rtl/fft_butterfly_unit_cmul.sv
// Two-stage Q1.15 complex multiply P = W*B with round-to-nearest.
// Ports: clk, rst_n, en (stage advance), b_i, w_i in; pr_o/pi_o (DW+1 bits) out.
module fft_cmul_q15
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  cplx_t                b_i,
  input  cplx_t                w_i,
  output logic signed [DW:0]   pr_o,
  output logic signed [DW:0]   pi_o
);

  logic signed [2*DW-1:0] brwr_q;
  logic signed [2*DW-1:0] biwi_q;
  logic signed [2*DW-1:0] brwi_q;
  logic signed [2*DW-1:0] biwr_q;

  logic signed [2*DW:0] pr_d;
  logic signed [2*DW:0] pi_d;

  logic signed [2*DW-1:0] brwr_d;
  logic signed [2*DW-1:0] biwi_d;
  logic signed [2*DW-1:0] brwi_d;
  logic signed [2*DW-1:0] biwr_d;

  assign brwr_d = $signed(b_i.re) * $signed(w_i.re);
  assign biwi_d = $signed(b_i.im) * $signed(w_i.im);
  assign brwi_d = $signed(b_i.re) * $signed(w_i.im);
  assign biwr_d = $signed(b_i.im) * $signed(w_i.re);

  // Rounding offset added before the arithmetic shift.
  assign pr_d = (2*DW+1)'(brwr_q) - (2*DW+1)'(biwi_q)
              + RND_Q15;
  assign pi_d = (2*DW+1)'(brwi_q) + (2*DW+1)'(biwr_q)
              + RND_Q15;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brwr_q <= '0;
      biwi_q <= '0;
      brwi_q <= '0;
      biwr_q <= '0;
      pr_o   <= '0;
      pi_o   <= '0;
    end else if (en) begin
      brwr_q <= brwr_d;
      biwi_q <= biwi_d;
      brwi_q <= brwi_d;
      biwr_q <= biwr_d;
      // >>> (DW-1), keeping the low DW+1 bits.
      pr_o   <= pr_d[2*DW-1:DW-1];
      pi_o   <= pi_d[2*DW-1:DW-1];
    end
  end

endmodule

// File: rtl/fft_butterfly_unit.sv
// Pipelined radix-2 DIT butterfly: X = A + W*B, Y = A - W*B (Q1.15), 4 stages.
// Ports: valid/ready in/out, A/B/tw_idx in, Tw_addr/Tw_* ROM, x/y out. Option: BFLY_SCALE_EN.
module fft_butterfly_unit
  import fft_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [DW-1:0]    a_real,
  input  logic signed [DW-1:0]    a_imag,
  input  logic signed [DW-1:0]    b_real,
  input  logic signed [DW-1:0]    b_imag,
  input  logic [TW_AW-1:0]        tw_idx,
  output logic [TW_AW-1:0]        Tw_addr,
  input  logic signed [DW-1:0]    Tw_real,
  input  logic signed [DW-1:0]    Tw_imag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [DW-1:0]    x_real,
  output logic signed [DW-1:0]    x_imag,
  output logic signed [DW-1:0]    y_real,
  output logic signed [DW-1:0]    y_imag
);

  localparam logic signed [DW+1:0] ONE =
    (DW+2)'(1);

  logic adv;
  logic v1_q, v2_q, v3_q;
  cplx_t a1_q, a2_q, a3_q, b1_q;
  cplx_t w;
  logic signed [DW:0] pr, pi;

  logic signed [DW+1:0] xr_s, xi_s;
  logic signed [DW+1:0] yr_s, yi_s;
  logic signed [DW-1:0] xr_d, xi_d;
  logic signed [DW-1:0] yr_d, yi_d;

  // Whole pipeline steps together.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  assign w = '{re: Tw_real, im: Tw_imag};

  fft_cmul_q15 u_cmul (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv),
    .b_i   (b1_q),
    .w_i   (w),
    .pr_o  (pr),
    .pi_o  (pi)
  );

  assign xr_s = (DW+2)'($signed(a3_q.re)) + (DW+2)'(pr);
  assign xi_s = (DW+2)'($signed(a3_q.im)) + (DW+2)'(pi);
  assign yr_s = (DW+2)'($signed(a3_q.re)) - (DW+2)'(pr);
  assign yi_s = (DW+2)'($signed(a3_q.im)) - (DW+2)'(pi);

`ifdef BFLY_SCALE_EN
  // Halve with round-half-up before clamping.
  assign xr_d = sat_dw((xr_s + ONE) >>> 1);
  assign xi_d = sat_dw((xi_s + ONE) >>> 1);
  assign yr_d = sat_dw((yr_s + ONE) >>> 1);
  assign yi_d = sat_dw((yi_s + ONE) >>> 1);
`else
  assign xr_d = sat_dw(xr_s);
  assign xi_d = sat_dw(xi_s);
  assign yr_d = sat_dw(yr_s);
  assign yi_d = sat_dw(yi_s);
  logic unused_one;
  assign unused_one = ^ONE;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      out_valid <= 1'b0;
      a1_q      <= '0;
      a2_q      <= '0;
      a3_q      <= '0;
      b1_q      <= '0;
      Tw_addr   <= '0;
      x_real    <= '0;
      x_imag    <= '0;
      y_real    <= '0;
      y_imag    <= '0;
    end else if (adv) begin
      v1_q      <= in_valid;
      v2_q      <= v1_q;
      v3_q      <= v2_q;
      out_valid <= v3_q;
      if (in_valid) begin
        a1_q    <= '{re: a_real, im: a_imag};
        b1_q    <= '{re: b_real, im: b_imag};
        Tw_addr <= tw_idx;
      end
      a2_q <= a1_q;
      a3_q <= a2_q;
      // Bubbles leave the last result on x/y.
      if (v3_q) begin
        x_real <= xr_d;
        x_imag <= xi_d;
        y_real <= yr_d;
        y_imag <= yi_d;
      end
    end
  end

endmodule

// File: tb/tb_fft_butterfly_unit.sv
// Randomised and directed bench for fft_butterfly_unit with a ROM model.
// Queue-based arithmetic reference; honours BFLY_SCALE_EN.
module tb_fft_butterfly_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic out_valid;
  logic out_ready = 1'b1;
  logic signed [15:0] a_real = '0, a_imag = '0;
  logic signed [15:0] b_real = '0, b_imag = '0;
  logic [3:0] tw_idx = '0;
  logic [3:0] Tw_addr;
  logic signed [15:0] Tw_real, Tw_imag;
  logic signed [15:0] x_real, x_imag, y_real, y_imag;

  logic signed [15:0] rom_re [16];
  logic signed [15:0] rom_im [16];

  assign Tw_real = rom_re[Tw_addr];
  assign Tw_imag = rom_im[Tw_addr];

  always #5 clk = ~clk;

  fft_butterfly_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_real    (a_real),
    .a_imag    (a_imag),
    .b_real    (b_real),
    .b_imag    (b_imag),
    .tw_idx    (tw_idx),
    .Tw_addr   (Tw_addr),
    .Tw_real   (Tw_real),
    .Tw_imag   (Tw_imag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_real    (x_real),
    .x_imag    (x_imag),
    .y_real    (y_real),
    .y_imag    (y_imag)
  );

  typedef struct {
    int xr; int xi; int yr; int yi;
  } res_t;

  res_t exp_q[$];
  res_t last;
  int nchecks = 0;
  int nerr = 0;
  int pops = 0;
  int exp_addr = 0;
  logic mon_acc = 1'b0;
  logic mon_ov = 1'b0;
  int mon_xr, mon_xi, mon_yr, mon_yi;

`ifdef BFLY_SCALE_EN
  localparam int T1XR = 1500, T1YR = -500;
  localparam int T2XI = -2048, T2YI = 2048;
`else
  localparam int T1XR = 3000, T1YR = -1000;
  localparam int T2XI = -4096, T2YI = 4096;
`endif

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic longint wrap17(input longint v);
    longint r;
    r = v & 64'h1FFFF;
    if (r >= 65536) r = r - 131072;
    return r;
  endfunction

  function automatic int fin(input longint s);
    longint t;
    t = s;
`ifdef BFLY_SCALE_EN
    t = (t + 1) >>> 1;
`endif
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
    return int'(t);
  endfunction

  function automatic res_t model(
    input longint ar, input longint ai,
    input longint br, input longint bi,
    input longint wr, input longint wi);
    longint pr, pi;
    res_t r;
    pr = wrap17((br*wr - bi*wi + 16384) >>> 15);
    pi = wrap17((br*wi + bi*wr + 16384) >>> 15);
    r.xr = fin(ar + pr);
    r.xi = fin(ai + pi);
    r.yr = fin(ar - pr);
    r.yi = fin(ai - pi);
    return r;
  endfunction

  task automatic monitor();
    mon_xr = x_real; mon_xi = x_imag;
    mon_yr = y_real; mon_yi = y_imag;
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_x_real", x_real, 0);
      chk("rst_x_imag", x_imag, 0);
      chk("rst_y_real", y_real, 0);
      chk("rst_y_imag", y_imag, 0);
      chk("rst_tw_addr", Tw_addr, 0);
      exp_q.delete();
      last = '{0, 0, 0, 0};
      exp_addr = 0;
      mon_acc = 1'b0;
      mon_ov = 1'b0;
      return;
    end
    mon_acc = in_valid & in_ready;
    mon_ov = out_valid;
    chk("in_ready", in_ready, !out_valid || out_ready);
    chk("tw_addr", Tw_addr, exp_addr);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", out_valid, 0);
      end else begin
        chk("x_real", x_real, exp_q[0].xr);
        chk("x_imag", x_imag, exp_q[0].xi);
        chk("y_real", y_real, exp_q[0].yr);
        chk("y_imag", y_imag, exp_q[0].yi);
        if (out_ready) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
      last = '{x_real, x_imag, y_real, y_imag};
    end else begin
      chk("hold_x_real", x_real, last.xr);
      chk("hold_x_imag", x_imag, last.xi);
      chk("hold_y_real", y_real, last.yr);
      chk("hold_y_imag", y_imag, last.yi);
    end
    if (mon_acc) begin
      exp_q.push_back(model(a_real, a_imag,
        b_real, b_imag,
        rom_re[tw_idx], rom_im[tw_idx]));
      exp_addr = tw_idx;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int ar, input int ai,
                          input int br, input int bi,
                          input int idx);
    a_real = 16'(ar); a_imag = 16'(ai);
    b_real = 16'(br); b_imag = 16'(bi);
    tw_idx = 4'(idx);
  endtask

  task automatic rand_beat();
    set_beat(int'($urandom), int'($urandom),
             int'($urandom), int'($urandom),
             int'($urandom_range(15)));
  endtask

  task automatic send(input int ar, input int ai,
                      input int br, input int bi,
                      input int idx);
    set_beat(ar, ai, br, bi, idx);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (!mon_ov && k < 12);
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && k < 40) begin
      step();
      k++;
    end
    chk({nm, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int k, c, i, seen;
    logic acc_h [32];
    logic ov_h [32];

    for (int j = 0; j < 16; j++) begin
      rom_re[j] = 16'($urandom);
      rom_im[j] = 16'($urandom);
    end
    rom_re[0] = 16'sd32767; rom_im[0] = 16'sd0;
    rom_re[8] = 16'sd0;     rom_im[8] = -16'sd32767;

    step();
    step();
    rst_n = 1'b1;
    step();

    // 1: basic product with W = 1
    send(1000, 0, 2000, 0, 0);
    wait_out(k);
    chk("t1_latency", k, 4);
    chk("t1_x_real", mon_xr, T1XR);
    chk("t1_x_imag", mon_xi, 0);
    chk("t1_y_real", mon_yr, T1YR);
    chk("t1_y_imag", mon_yi, 0);
    drain("t1");

    // 2: W = -j, address registered on accept
    send(0, 0, 4096, 0, 8);
    chk("t2_tw_addr", Tw_addr, 8);
    wait_out(k);
    chk("t2_x_real", mon_xr, 0);
    chk("t2_x_imag", mon_xi, T2XI);
    chk("t2_y_real", mon_yr, 0);
    chk("t2_y_imag", mon_yi, T2YI);
    drain("t2");

    // 3: positive saturation
    send(32767, 0, 32767, 0, 0);
    wait_out(k);
    chk("t3_x_real", mon_xr, 32767);
    chk("t3_y_real", mon_yr, 1);
    drain("t3");

    // 4: 8 beats, stall on cycles 5-7
    pops = 0;
    i = 0;
    c = 0;
    while ((i < 8 || exp_q.size() != 0) && c < 60) begin
      out_ready = !(c >= 5 && c <= 7);
      in_valid = (i < 8);
      rand_beat();
      #1;
      if (c >= 5 && c <= 7)
        chk("t4_stall_in_ready", in_ready, 0);
      step();
      if (mon_acc) i++;
      c++;
    end
    chk("t4_results", pops, 8);
    drain("t4");

    // 5: reset with beats in flight
    for (int j = 0; j < 3; j++) begin
      rand_beat();
      tw_idx = 4'd5;
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_x_real", x_real, 0);
    chk("t5_y_imag", y_imag, 0);
    chk("t5_tw_addr", Tw_addr, 0);
    step();
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int j = 0; j < 10; j++) begin
      step();
      if (mon_ov) seen++;
    end
    chk("t5_stale_out", seen, 0);

    // 6: alternating bubbles
    out_ready = 1'b1;
    for (int j = 0; j < 24; j++) begin
      in_valid = (j < 16) && (j % 2 == 0);
      rand_beat();
      step();
      acc_h[j] = mon_acc;
      ov_h[j] = mon_ov;
      if (j >= 4)
        chk("t6_out_valid", ov_h[j], acc_h[j-4]);
    end
    drain("t6");

    // random traffic with backpressure
    for (int j = 0; j < 400; j++) begin
      in_valid = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      rand_beat();
      step();
    end
    drain("rand");

    $display("Simulation finished: %0d checks, %0d errors",
             nchecks, nerr);
    $finish;
  end

endmodule
